// File: rtl/cpa_pkg.sv
// Shared defaults and control record for the pipelined carry-propagate adder.
package cpa_pkg;
   localparam int CPA_WIDTH = 16;
   localparam int CPA_CHUNK = 4;

   // Per-stage control part of the stage record; data fields depend on WIDTH.
   typedef struct packed {
      logic vld;
      logic carry;
      logic msb_c;
   } cpa_ctl_t;
endpackage

// File: rtl/cpa_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB.
module cpa_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             cmsb
);
   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[CHUNK];
   assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/cpa_pipe.sv
// Pipelined add/sub, one CHUNK slice per stage; result visible NSTAGE cycles after issue.
// Backpressure ripples combinationally from out_ready to in_ready; stalled stages hold.
module cpa_pipe
   import cpa_pkg::*;
#(
   parameter int WIDTH = CPA_WIDTH,
   parameter int CHUNK = CPA_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int NSTAGE = WIDTH / CHUNK;

   typedef struct packed {
      cpa_ctl_t         ctl;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } stage_t;

   stage_t            st_q [NSTAGE];
   logic [NSTAGE-1:0] adv;

   always_comb begin
      adv           = '0;
      adv[NSTAGE-1] = !st_q[NSTAGE-1].ctl.vld || out_ready;
      for (int k = NSTAGE - 2; k >= 0; k--) begin
         adv[k] = !st_q[k].ctl.vld || adv[k+1];
      end
   end

   assign in_ready = adv[0];

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      stage_t           src;
      stage_t           stage_d;
      logic [CHUNK-1:0] sl_s;
      logic             sl_cout;
      logic             sl_cmsb;

      if (k == 0) begin : g_first
         // Subtraction is a + ~b + 1, so the operand is inverted once on entry.
         always_comb begin
            src           = '0;
            src.ctl.vld   = in_valid;
            src.ctl.carry = sub ? 1'b1 : cin;
            src.a         = a;
            src.b         = b ^ {WIDTH{sub}};
         end
      end else begin : g_next
         assign src = st_q[k-1];
      end

      cpa_slice #(.CHUNK(CHUNK)) u_slice (
         .a    (src.a[k*CHUNK +: CHUNK]),
         .b    (src.b[k*CHUNK +: CHUNK]),
         .cin  (src.ctl.carry),
         .s    (sl_s),
         .cout (sl_cout),
         .cmsb (sl_cmsb)
      );

      always_comb begin
         stage_d                       = src;
         stage_d.sum[k*CHUNK +: CHUNK] = sl_s;
         stage_d.ctl.carry             = sl_cout;
         stage_d.ctl.msb_c             = sl_cmsb;
      end

      // Data only loads with a valid beat, so idle X inputs never reach the outputs.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q[k] <= '0;
         end else if (adv[k]) begin
            if (src.ctl.vld) begin
               st_q[k] <= stage_d;
            end else begin
               st_q[k].ctl.vld <= 1'b0;
            end
         end
      end
   end

   assign out_valid = st_q[NSTAGE-1].ctl.vld;
   assign s         = st_q[NSTAGE-1].sum;
   assign cout      = st_q[NSTAGE-1].ctl.carry;
   assign ovf       = st_q[NSTAGE-1].ctl.carry ^ st_q[NSTAGE-1].ctl.msb_c;
endmodule
